tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 155 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: 10b symbol decode plus word-alignment (bitslip) FSM.
// One instance per channel; outputs are registered with one cycle of latency.
module tmds_channel_decoder #(
   parameter int unsigned WINDOW       = 2048,
   parameter int unsigned LOCK_TOKENS  = 128,
   parameter int unsigned SETTLE       = 16,
   parameter int unsigned LOSS_TIMEOUT = 4096
) (
   input  logic       i_pix_clk,
   input  logic       i_rst,
   input  logic [9:0] i_symbol,
   output logic [7:0] o_data,
   output logic       o_de,
   output logic [1:0] o_ctrl,
   output logic       o_bitslip,
   output logic       o_locked,
   output logic [3:0] o_slip_count
);

   localparam int unsigned WIN_W  = (WINDOW > 1)       ? $clog2(WINDOW)        : 1;
   localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
   localparam int unsigned SET_W  = (SETTLE > 1)       ? $clog2(SETTLE)        : 1;
   localparam int unsigned LOSS_W = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT)  : 1;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_SLIP   = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [WIN_W-1:0]  win_cnt, win_nxt;
   logic [TOK_W-1:0]  tok_cnt, tok_nxt;
   logic [SET_W-1:0]  set_cnt, set_nxt;
   logic [LOSS_W-1:0] loss_cnt, loss_nxt;
   logic [3:0]        slip_cnt_nxt;
   logic              bitslip_nxt;

   logic              is_tok;
   logic [1:0]        tok_val;
   logic [7:0]        t;
   logic [7:0]        x;
   logic [7:0]        data_dec;

   // Classify the symbol and undo the TMDS transition-minimising encode.
   always_comb begin
      is_tok  = 1'b1;
      tok_val = 2'b00;
      case (i_symbol)
         10'b1101010100: tok_val = 2'b00;
         10'b0010101011: tok_val = 2'b01;
         10'b0101010100: tok_val = 2'b10;
         10'b1010101011: tok_val = 2'b11;
         default:        is_tok  = 1'b0;
      endcase
      t = i_symbol[9] ? ~i_symbol[7:0] : i_symbol[7:0];
      x = t ^ {t[6:0], 1'b0};
      data_dec = i_symbol[8] ? {x[7:1], t[0]} : {~x[7:1], t[0]};
   end

   // Alignment FSM next-state and counter updates.
   always_comb begin
      state_nxt    = state;
      win_nxt      = win_cnt;
      tok_nxt      = tok_cnt;
      set_nxt      = set_cnt;
      loss_nxt     = loss_cnt;
      slip_cnt_nxt = o_slip_count;
      bitslip_nxt  = 1'b0;
      case (state)
         ST_SEARCH: begin
            // Lock is tested first so it wins over a coincident window end.
            if (tok_cnt == TOK_W'(LOCK_TOKENS)) begin
               state_nxt = ST_LOCKED;
               loss_nxt  = '0;
            end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
               state_nxt   = ST_SLIP;
               bitslip_nxt = 1'b1;
               if (o_slip_count != 4'hF) slip_cnt_nxt = o_slip_count + 4'd1;
            end else begin
               win_nxt = win_cnt + WIN_W'(1);
               if (is_tok) tok_nxt = tok_cnt + TOK_W'(1);
            end
         end
         ST_SLIP: begin
            state_nxt = ST_WAIT;
            set_nxt   = '0;
         end
         ST_WAIT: begin
            if (set_cnt == SET_W'(SETTLE - 1)) begin
               state_nxt = ST_SEARCH;
               win_nxt   = '0;
               tok_nxt   = '0;
            end else begin
               set_nxt = set_cnt + SET_W'(1);
            end
         end
         ST_LOCKED: begin
            if (is_tok) begin
               loss_nxt = '0;
            end else if (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1)) begin
               state_nxt = ST_SEARCH;
               win_nxt   = '0;
               tok_nxt   = '0;
               loss_nxt  = '0;
            end else begin
               loss_nxt = loss_cnt + LOSS_W'(1);
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   // FSM state, counters and alignment status outputs.
   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         state        <= ST_SEARCH;
         win_cnt      <= '0;
         tok_cnt      <= '0;
         set_cnt      <= '0;
         loss_cnt     <= '0;
         o_bitslip    <= 1'b0;
         o_locked     <= 1'b0;
         o_slip_count <= 4'd0;
      end else begin
         state        <= state_nxt;
         win_cnt      <= win_nxt;
         tok_cnt      <= tok_nxt;
         set_cnt      <= set_nxt;
         loss_cnt     <= loss_nxt;
         o_bitslip    <= bitslip_nxt;
         o_locked     <= (state_nxt == ST_LOCKED);
         o_slip_count <= slip_cnt_nxt;
      end
   end

   // Decoded pixel/control outputs; data is only passed while aligned.
   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         o_data <= 8'd0;
         o_de   <= 1'b0;
         o_ctrl <= 2'b00;
      end else if (is_tok) begin
         o_data <= 8'd0;
         o_de   <= 1'b0;
         o_ctrl <= tok_val;
      end else if (state == ST_LOCKED) begin
         o_data <= data_dec;
         o_de   <= 1'b1;
      end else begin
         o_data <= 8'd0;
         o_de   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: behavioural model checked every cycle plus
// literal pins on lock timing, bitslip timing and saturation.
module tb_tmds_channel_decoder;

   localparam int WINDOW       = 2048;
   localparam int LOCK_TOKENS  = 128;
   localparam int SETTLE       = 16;
   localparam int LOSS_TIMEOUT = 4096;

   localparam int P_HUNT = 0, P_PULSE = 1, P_SETTLE = 2, P_ALIGNED = 3;

   logic       clk;
   logic       rst;
   logic [9:0] sym;
   logic [7:0] data;
   logic       de;
   logic [1:0] ctrl;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_count;

   int total = 0;
   int bad   = 0;

   logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

   // model state
   int         phase, hunt_cyc, hunt_tok, settle_cyc, quiet;
   logic [7:0] e_data;
   logic       e_de, e_slip, e_lock;
   logic [1:0] e_ctrl;
   int         e_cnt;
   int         enc_disp;

   tmds_channel_decoder dut (
      .i_pix_clk    (clk),
      .i_rst        (rst),
      .i_symbol     (sym),
      .o_data       (data),
      .o_de         (de),
      .o_ctrl       (ctrl),
      .o_bitslip    (bitslip),
      .o_locked     (locked),
      .o_slip_count (slip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic token_of(input logic [9:0] s, output logic [1:0] c);
      c = 2'b00;
      for (int k = 0; k < 4; k++)
         if (s == tok_tab[k]) begin
            c = 2'(k);
            return 1'b1;
         end
      return 1'b0;
   endfunction

   // Transition-minimised form of byte b in xor (xm=1) or xnor mode.
   function automatic logic [7:0] fwd(input logic [7:0] b, input logic xm);
      logic [7:0] q;
      q[0] = b[0];
      for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
      return q;
   endfunction

   // Recover the byte by searching for the one whose forward encode matches.
   function automatic logic [7:0] inv_decode(input logic [9:0] s);
      logic [7:0] tt;
      tt = s[9] ? ~s[7:0] : s[7:0];
      for (int b = 0; b < 256; b++)
         if (fwd(8'(b), s[8]) == tt) return 8'(b);
      return 8'hxx;
   endfunction

   // Full DC-balanced DVI encoder, as on the transmit side.
   task automatic encode(input logic [7:0] d, output logic [9:0] q);
      int n1d, n1, n0;
      logic xm;
      logic [7:0] qm;
      n1d = $countones(d);
      xm  = !((n1d > 4) || (n1d == 4 && d[0] == 1'b0));
      qm  = fwd(d, xm);
      n1  = $countones(qm);
      n0  = 8 - n1;
      if (enc_disp == 0 || n1 == n0) begin
         q = {~xm, xm, xm ? qm : ~qm};
         enc_disp += xm ? (n1 - n0) : (n0 - n1);
      end else if ((enc_disp > 0 && n1 > n0) || (enc_disp < 0 && n0 > n1)) begin
         q = {1'b1, xm, ~qm};
         enc_disp += (xm ? 2 : 0) + n0 - n1;
      end else begin
         q = {1'b0, xm, qm};
         enc_disp += (xm ? 0 : -2) + n1 - n0;
      end
   endtask

   // Advance the behavioural model by one clock edge.
   task automatic model(input logic [9:0] s, input logic r);
      logic       tk;
      logic [1:0] cv;
      tk = token_of(s, cv);
      e_slip = 1'b0;
      if (r) begin
         phase = P_HUNT; hunt_cyc = 0; hunt_tok = 0; settle_cyc = 0; quiet = 0;
         e_data = 8'd0; e_de = 1'b0; e_ctrl = 2'b00; e_cnt = 0;
      end else begin
         if (tk) begin
            e_de = 1'b0; e_ctrl = cv; e_data = 8'd0;
         end else if (phase == P_ALIGNED) begin
            e_de = 1'b1; e_data = inv_decode(s);
         end else begin
            e_de = 1'b0; e_data = 8'd0;
         end
         case (phase)
            P_HUNT:
               if (hunt_tok >= LOCK_TOKENS) begin
                  phase = P_ALIGNED; quiet = 0;
               end else if (hunt_cyc == WINDOW - 1) begin
                  phase = P_PULSE; e_slip = 1'b1;
                  if (e_cnt < 15) e_cnt++;
               end else begin
                  hunt_cyc++;
                  if (tk) hunt_tok++;
               end
            P_PULSE: begin
               phase = P_SETTLE; settle_cyc = 0;
            end
            P_SETTLE:
               if (settle_cyc == SETTLE - 1) begin
                  phase = P_HUNT; hunt_cyc = 0; hunt_tok = 0;
               end else settle_cyc++;
            default:
               if (tk) quiet = 0;
               else begin
                  quiet++;
                  if (quiet == LOSS_TIMEOUT) begin
                     phase = P_HUNT; hunt_cyc = 0; hunt_tok = 0; quiet = 0;
                  end
               end
         endcase
      end
      e_lock = (phase == P_ALIGNED);
   endtask

   // Compare every DUT output with the model, away from the active edge.
   task automatic check_all();
      cmp("data", 32'(data), 32'(e_data));
      cmp("de", 32'(de), 32'(e_de));
      cmp("ctrl", 32'(ctrl), 32'(e_ctrl));
      cmp("bitslip", 32'(bitslip), 32'(e_slip));
      cmp("locked", 32'(locked), 32'(e_lock));
      cmp("slip_count", 32'(slip_count), 32'(e_cnt));
   endtask

   task automatic step(input logic [9:0] s, input logic r);
      sym = s;
      rst = r;
      model(s, r);
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [9:0] rand_nontoken();
      logic [9:0] s;
      logic [1:0] c;
      do s = 10'($urandom_range(0, 1023)); while (token_of(s, c));
      return s;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] q;
      encode(b, q);
      step(q, 1'b0);
   endtask

   task automatic expect_zero_outputs(input string tag);
      cmp({tag, "_data"}, 32'(data), 32'd0);
      cmp({tag, "_de"}, 32'(de), 32'd0);
      cmp({tag, "_ctrl"}, 32'(ctrl), 32'd0);
      cmp({tag, "_bitslip"}, 32'(bitslip), 32'd0);
      cmp({tag, "_locked"}, 32'(locked), 32'd0);
      cmp({tag, "_slips"}, 32'(slip_count), 32'd0);
   endtask

   initial begin
      int n, m, pulses;
      logic [7:0] b;
      rst = 1'b1;
      sym = 10'd0;
      enc_disp = 0;
      step(10'd0, 1'b1);
      step(10'd0, 1'b1);
      expect_zero_outputs("reset");

      // Lock on a clean stream of ctrl=00 tokens.
      for (int k = 0; k < LOCK_TOKENS; k++) step(tok_tab[0], 1'b0);
      cmp("lock_not_yet", 32'(locked), 32'd0);
      step(tok_tab[0], 1'b0);
      cmp("lock_after_tokens", 32'(locked), 32'd1);
      cmp("lock_ctrl", 32'(ctrl), 32'd0);
      cmp("lock_de", 32'(de), 32'd0);
      cmp("lock_no_slip", 32'(slip_count), 32'd0);

      // Hand-decoded data symbols.
      step(10'b0100000000, 1'b0);
      cmp("sym_100_data", 32'(data), 32'h00);
      cmp("sym_100_de", 32'(de), 32'd1);
      step(10'b1111111111, 1'b0);
      cmp("sym_3ff_data", 32'(data), 32'h00);
      // inverted t=0x00 in xnor mode yields 0xFE
      step(10'b1011111111, 1'b0);
      cmp("sym_2ff_data", 32'(data), 32'hFE);

      // Byte sweep through the reference encoder.
      enc_disp = 0;
      for (int k = 0; k < 256; k++) begin
         send_byte(8'(k));
         cmp("sweep_data", 32'(data), 32'(k));
         cmp("sweep_de", 32'(de), 32'd1);
      end

      // Random mix of data and control tokens while locked.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            enc_disp = 0;
            step(tok_tab[$urandom_range(0, 3)], 1'b0);
         end else begin
            b = 8'($urandom_range(0, 255));
            send_byte(b);
         end
      end

      // Loss of lock after a long data-only run.
      step(tok_tab[2], 1'b0);
      enc_disp = 0;
      for (int k = 0; k < LOSS_TIMEOUT - 1; k++) send_byte(8'($urandom_range(0, 255)));
      cmp("loss_not_yet", 32'(locked), 32'd1);
      send_byte(8'($urandom_range(0, 255)));
      cmp("loss_dropped", 32'(locked), 32'd0);
      cmp("loss_no_slip", 32'(bitslip), 32'd0);

      // Video lines with blanking tokens must relock within a window.
      for (int line = 0; line < 2; line++) begin
         for (int k = 0; k < 256; k++) step(tok_tab[$urandom_range(0, 3)], 1'b0);
         enc_disp = 0;
         for (int k = 0; k < 800; k++) send_byte(8'($urandom_range(0, 255)));
         if (line == 0) begin
            cmp("relock", 32'(locked), 32'd1);
            cmp("relock_slips", 32'(slip_count), 32'd0);
         end
      end

      // Misaligned stream: first and second bitslip timing.
      step(10'd0, 1'b1);
      expect_zero_outputs("reset2");
      n = 0;
      for (int k = 1; k <= WINDOW + 50; k++) begin
         step(rand_nontoken(), 1'b0);
         if (bitslip) begin n = k; break; end
      end
      cmp("slip1_cycle", 32'(n), 32'(WINDOW));
      cmp("slip1_count", 32'(slip_count), 32'd1);
      m = 0;
      for (int k = 1; k <= WINDOW + SETTLE + 50; k++) begin
         step(rand_nontoken(), 1'b0);
         if (bitslip) begin m = k; break; end
      end
      cmp("slip2_gap", 32'(m), 32'(WINDOW + 1 + SETTLE));

      // Run to five slips, then reset while settling.
      for (int k = 0; k < 4 * (WINDOW + SETTLE + 1); k++) begin
         step(10'($urandom_range(0, 1023)), 1'b0);
         if (slip_count == 4'd5) break;
      end
      cmp("five_slips", 32'(slip_count), 32'd5);
      for (int k = 0; k < 4; k++) step(rand_nontoken(), 1'b0);
      step(rand_nontoken(), 1'b1);
      expect_zero_outputs("reset_in_wait");

      // Twenty slips: pulses keep coming, the counter saturates.
      pulses = 0;
      n = 0;
      for (int k = 1; k <= 20 * (WINDOW + SETTLE + 1) + 100; k++) begin
         step(10'($urandom_range(0, 1023)), 1'b0);
         if (bitslip) begin
            pulses++;
            if (pulses == 1) n = k;
            if (pulses == 20) break;
         end
      end
      cmp("restart_slip_cycle", 32'(n), 32'(WINDOW));
      cmp("slip_pulses", 32'(pulses), 32'd20);
      cmp("slip_saturated", 32'(slip_count), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
